// File: rtl/fb_draw_ctrl_if.sv
// Command and RAM-read bus of the CHIP-8 framebuffer controller.
// slave: controller view; master: CPU/RAM side view.
interface fb_draw_ctrl_if #(
    parameter int unsigned ADDR_W = 12
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_op;
    logic [7:0]        cmd_x;
    logic [7:0]        cmd_y;
    logic [3:0]        cmd_n;
    logic [ADDR_W-1:0] cmd_addr;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_rd_data;
    logic              done;
    logic              collision;

    modport slave (
        input  cmd_valid, cmd_op, cmd_x, cmd_y, cmd_n, cmd_addr, mem_rd_data,
        output cmd_ready, mem_rd_en, mem_addr, done, collision
    );

    modport master (
        output cmd_valid, cmd_op, cmd_x, cmd_y, cmd_n, cmd_addr, mem_rd_data,
        input  cmd_ready, mem_rd_en, mem_addr, done, collision
    );
endinterface

// File: rtl/fb_draw_ctrl.sv
// CHIP-8 framebuffer controller: owns the 64x32 video memory, executes
// DRAW (DXYN, sprite XOR with collision) and CLEAR (00E0) commands.
// Optional macro FB_DRAW_CLIP_EN: clip sprites at the right/bottom edges
// instead of wrapping; fetch timing is unchanged.
module fb_draw_ctrl #(
    parameter int unsigned ADDR_W     = 12,
    parameter int unsigned MEM_RD_LAT = 1
) (
    input  logic          SYS_CLK,
    input  logic          SYS_RST_N,
    fb_draw_ctrl_if.slave bus,
    output logic [0:2047] flat_video_memory
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_CLR,
        S_DONE
    } state_t;

    localparam logic [1:0] LAT_M1 = 2'(MEM_RD_LAT - 1);

    state_t            state_q, state_d;
    logic [5:0]        x0_q, x0_d;
    logic [4:0]        y0_q, y0_d;
    logic [3:0]        n_q, n_d;
    logic [3:0]        r_q, r_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [1:0]        wcnt_q, wcnt_d;
    logic [4:0]        clr_row_q, clr_row_d;
    logic              coll_q, coll_d;
    logic [0:2047]     fb_q, fb_d;

    logic [6:0]        col_full;
    logic [5:0]        row_full;
    logic [10:0]       pix_idx;
    logic              pix_on;
    logic [3:0]        r_inc;
    logic              unused_ok;

    // State, command latches and framebuffer registers
    always_ff @(posedge SYS_CLK or negedge SYS_RST_N) begin
        if (!SYS_RST_N) begin
            state_q    <= S_IDLE;
            x0_q       <= '0;
            y0_q       <= '0;
            n_q        <= '0;
            r_q        <= '0;
            addr_q     <= '0;
            mem_addr_q <= '0;
            wcnt_q     <= '0;
            clr_row_q  <= '0;
            coll_q     <= 1'b0;
            fb_q       <= '0;
        end else begin
            state_q    <= state_d;
            x0_q       <= x0_d;
            y0_q       <= y0_d;
            n_q        <= n_d;
            r_q        <= r_d;
            addr_q     <= addr_d;
            mem_addr_q <= mem_addr_d;
            wcnt_q     <= wcnt_d;
            clr_row_q  <= clr_row_d;
            coll_q     <= coll_d;
            fb_q       <= fb_d;
        end
    end

    // Next-state logic: command acceptance, row fetch/XOR, row-wise clear
    always_comb begin
        state_d    = state_q;
        x0_d       = x0_q;
        y0_d       = y0_q;
        n_d        = n_q;
        r_d        = r_q;
        addr_d     = addr_q;
        mem_addr_d = mem_addr_q;
        wcnt_d     = wcnt_q;
        clr_row_d  = clr_row_q;
        coll_d     = coll_q;
        fb_d       = fb_q;
        col_full   = '0;
        row_full   = '0;
        pix_idx    = '0;
        pix_on     = 1'b0;
        r_inc      = r_q + 4'd1;

        case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    x0_d      = bus.cmd_x[5:0];
                    y0_d      = bus.cmd_y[4:0];
                    n_d       = bus.cmd_n;
                    addr_d    = bus.cmd_addr;
                    r_d       = '0;
                    coll_d    = 1'b0;
                    clr_row_d = '0;
                    if (bus.cmd_op) begin
                        state_d = S_CLR;
                    end else if (bus.cmd_n == 4'd0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d    = S_FETCH;
                        mem_addr_d = bus.cmd_addr;
                    end
                end
            end
            S_FETCH: begin
                wcnt_d  = LAT_M1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (wcnt_q != 2'd0) begin
                    wcnt_d = wcnt_q - 2'd1;
                end else begin
                    // Unwrapped coordinates keep the overflow bit so clip mode
                    // can reject off-screen pixels; wrap mode drops it.
                    for (int unsigned b = 0; b < 8; b++) begin
                        col_full = {1'b0, x0_q} + 7'(b);
                        row_full = {1'b0, y0_q} + {2'b00, r_q};
                        pix_idx  = {row_full[4:0], col_full[5:0]};
`ifdef FB_DRAW_CLIP_EN
                        pix_on = bus.mem_rd_data[3'(7 - b)] && !col_full[6] && !row_full[5];
`else
                        pix_on = bus.mem_rd_data[3'(7 - b)];
`endif
                        if (pix_on) begin
                            if (fb_q[pix_idx]) begin
                                coll_d = 1'b1;
                            end
                            fb_d[pix_idx] = ~fb_q[pix_idx];
                        end
                    end
                    r_d = r_inc;
                    if (r_inc == n_q) begin
                        state_d = S_DONE;
                    end else begin
                        state_d    = S_FETCH;
                        mem_addr_d = addr_q + ADDR_W'(r_inc);
                    end
                end
            end
            S_CLR: begin
                for (int unsigned c = 0; c < 64; c++) begin
                    fb_d[{clr_row_q, 6'(c)}] = 1'b0;
                end
                clr_row_d = clr_row_q + 5'd1;
                if (clr_row_q == 5'd31) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.cmd_ready      = (state_q == S_IDLE);
    assign bus.mem_rd_en      = (state_q == S_FETCH);
    assign bus.mem_addr       = mem_addr_q;
    assign bus.done           = (state_q == S_DONE);
    assign bus.collision      = coll_q;
    assign flat_video_memory  = fb_q;

    assign unused_ok = ^{bus.cmd_x[7:6], bus.cmd_y[7:5], col_full[6], row_full[5]};
endmodule

// File: tb/tb_fb_draw_ctrl.sv
// Directed bench for fb_draw_ctrl: one instance with 1-cycle RAM latency,
// one with 3-cycle latency for the busy/handshake sequence.
module tb_fb_draw_ctrl;
    logic SYS_CLK   = 1'b0;
    logic SYS_RST_N = 1'b0;
    always #5 SYS_CLK = ~SYS_CLK;

    fb_draw_ctrl_if #(.ADDR_W(12)) bus_a ();
    fb_draw_ctrl_if #(.ADDR_W(12)) bus_b ();
    logic [0:2047] fb_a;
    logic [0:2047] fb_b;

    fb_draw_ctrl #(.ADDR_W(12), .MEM_RD_LAT(1)) dut_a (
        .SYS_CLK           (SYS_CLK),
        .SYS_RST_N         (SYS_RST_N),
        .bus               (bus_a),
        .flat_video_memory (fb_a)
    );

    fb_draw_ctrl #(.ADDR_W(12), .MEM_RD_LAT(3)) dut_b (
        .SYS_CLK           (SYS_CLK),
        .SYS_RST_N         (SYS_RST_N),
        .bus               (bus_b),
        .flat_video_memory (fb_b)
    );

    // Shared sprite RAM, one read pipeline per instance
    logic [7:0] mem [0:4095];
    logic [7:0] rd_a = '0;
    logic [7:0] pb1  = '0;
    logic [7:0] pb2  = '0;
    logic [7:0] pb3  = '0;
    always @(posedge SYS_CLK) if (bus_a.mem_rd_en) rd_a <= mem[bus_a.mem_addr];
    always @(posedge SYS_CLK) begin
        if (bus_b.mem_rd_en) pb1 <= mem[bus_b.mem_addr];
        pb2 <= pb1;
        pb3 <= pb2;
    end
    assign bus_a.mem_rd_data = rd_a;
    assign bus_b.mem_rd_data = pb3;

    int total = 0;
    int bad   = 0;
    logic [0:2047] exp_fb;
    int rd_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_fb(input string tag, input logic [0:2047] obs, input logic [0:2047] exp);
        int nd;
        int first;
        nd = 0;
        first = -1;
        for (int i = 0; i < 2048; i++) begin
            if (obs[i] !== exp[i]) begin
                nd++;
                if (first < 0) first = i;
            end
        end
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s diff_bits=%0d first_idx=%0d got=%b exp=%b", tag, nd, first,
                   (first >= 0) ? obs[first] : 1'b0, (first >= 0) ? exp[first] : 1'b0);
        end
    endtask

    task automatic px(input int x, input int y);
        exp_fb[y*64 + x] = ~exp_fb[y*64 + x];
    endtask

    task automatic glyph0(input int x, input int y);
        for (int i = 0; i < 4; i++) begin
            px(x + i, y);
            px(x + i, y + 4);
        end
        for (int j = 1; j < 4; j++) begin
            px(x, y + j);
            px(x + 3, y + j);
        end
    endtask

    // Issue one command on instance A and count cycles from the accept edge
    task automatic run_a(input logic op, input logic [7:0] x, input logic [7:0] y,
                         input logic [3:0] n, input logic [11:0] addr, output int done_cyc);
        done_cyc = -1;
        rd_q.delete();
        @(negedge SYS_CLK);
        bus_a.cmd_op    = op;
        bus_a.cmd_x     = x;
        bus_a.cmd_y     = y;
        bus_a.cmd_n     = n;
        bus_a.cmd_addr  = addr;
        bus_a.cmd_valid = 1'b1;
        @(posedge SYS_CLK);
        #1 bus_a.cmd_valid = 1'b0;
        for (int cyc = 1; cyc <= 60 && done_cyc < 0; cyc++) begin
            @(negedge SYS_CLK);
            if (bus_a.mem_rd_en) rd_q.push_back(int'(bus_a.mem_addr));
            if (bus_a.done) done_cyc = cyc;
        end
        @(negedge SYS_CLK);
        chk("done_single_pulse", 64'(bus_a.done), 64'd0);
    endtask

    initial begin
        int dc;
        int rdn;
        logic saw_done;
        int rdc[$];
        int dnc[$];
        int ryc[$];

        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        mem[12'h100] = 8'hF0; mem[12'h101] = 8'h90; mem[12'h102] = 8'h90;
        mem[12'h103] = 8'h90; mem[12'h104] = 8'hF0;
        mem[12'h200] = 8'hFF; mem[12'h201] = 8'h81;
        mem[12'hFFF] = 8'hC0; mem[12'h000] = 8'h01;
        mem[12'h300] = 8'h80; mem[12'h301] = 8'h80; mem[12'h302] = 8'h80;

        bus_a.cmd_valid = 1'b0; bus_a.cmd_op = 1'b0; bus_a.cmd_x = '0;
        bus_a.cmd_y = '0; bus_a.cmd_n = '0; bus_a.cmd_addr = '0;
        bus_b.cmd_valid = 1'b0; bus_b.cmd_op = 1'b0; bus_b.cmd_x = '0;
        bus_b.cmd_y = '0; bus_b.cmd_n = '0; bus_b.cmd_addr = '0;
        exp_fb = '0;

        // Reset state
        #12;
        chk("rst_cmd_ready", 64'(bus_a.cmd_ready), 64'd1);
        chk("rst_done", 64'(bus_a.done), 64'd0);
        chk("rst_collision", 64'(bus_a.collision), 64'd0);
        chk("rst_mem_rd_en", 64'(bus_a.mem_rd_en), 64'd0);
        chk("rst_mem_addr", 64'(bus_a.mem_addr), 64'd0);
        chk_fb("rst_fb", fb_a, exp_fb);
        @(negedge SYS_CLK);
        @(negedge SYS_CLK);
        SYS_RST_N = 1'b1;

        // "0" glyph at top-left
        run_a(1'b0, 8'd0, 8'd0, 4'd5, 12'h100, dc);
        chk("glyph_done_cyc", 64'(dc), 64'd11);
        chk("glyph_rd_n", 64'(rd_q.size()), 64'd5);
        chk("glyph_rd0", 64'(rd_q[0]), 64'h100);
        chk("glyph_rd4", 64'(rd_q[4]), 64'h104);
        chk("glyph_coll", 64'(bus_a.collision), 64'd0);
        chk("glyph_addr_hold", 64'(bus_a.mem_addr), 64'h104);
        glyph0(0, 0);
        chk_fb("glyph_fb", fb_a, exp_fb);

        // Same draw erases it and reports collision
        run_a(1'b0, 8'd0, 8'd0, 4'd5, 12'h100, dc);
        chk("erase_done_cyc", 64'(dc), 64'd11);
        chk("erase_coll", 64'(bus_a.collision), 64'd1);
        exp_fb = '0;
        chk_fb("erase_fb", fb_a, exp_fb);

        // New draw clears collision at accept; then CLEAR on a lit framebuffer
        run_a(1'b0, 8'd20, 8'd10, 4'd5, 12'h100, dc);
        chk("glyph2_coll", 64'(bus_a.collision), 64'd0);
        glyph0(20, 10);
        chk_fb("glyph2_fb", fb_a, exp_fb);
        run_a(1'b1, 8'd0, 8'd0, 4'd0, 12'h000, dc);
        chk("clear_done_cyc", 64'(dc), 64'd33);
        chk("clear_rd_n", 64'(rd_q.size()), 64'd0);
        chk("clear_coll", 64'(bus_a.collision), 64'd0);
        exp_fb = '0;
        chk_fb("clear_fb", fb_a, exp_fb);

        // Edge behaviour at bottom-right corner
        run_a(1'b0, 8'd62, 8'd31, 4'd2, 12'h200, dc);
        chk("edge_done_cyc", 64'(dc), 64'd5);
        chk("edge_rd0", 64'(rd_q[0]), 64'h200);
        chk("edge_rd1", 64'(rd_q[1]), 64'h201);
        chk("edge_coll", 64'(bus_a.collision), 64'd0);
        px(62, 31); px(63, 31);
`ifndef FB_DRAW_CLIP_EN
        for (int i = 0; i < 6; i++) px(i, 31);
        px(62, 0); px(5, 0);
`endif
        chk_fb("edge_fb", fb_a, exp_fb);

        // Coordinates taken mod 64/32, address wraps 0xFFF -> 0x000
        run_a(1'b0, 8'h45, 8'h22, 4'd2, 12'hFFF, dc);
        chk("amod_done_cyc", 64'(dc), 64'd5);
        chk("amod_rd0", 64'(rd_q[0]), 64'hFFF);
        chk("amod_rd1", 64'(rd_q[1]), 64'h000);
        px(5, 2); px(6, 2); px(12, 3);
        chk_fb("amod_fb", fb_a, exp_fb);

        // Zero-height draw
        run_a(1'b0, 8'd3, 8'd3, 4'd0, 12'h500, dc);
        chk("n0_done_cyc", 64'(dc), 64'd1);
        chk("n0_rd_n", 64'(rd_q.size()), 64'd0);
        chk("n0_addr_hold", 64'(bus_a.mem_addr), 64'h000);
        chk_fb("n0_fb", fb_a, exp_fb);

        // Reset during the row-3 fetch of a 5-row draw
        rdn = 0;
        saw_done = 1'b0;
        @(negedge SYS_CLK);
        bus_a.cmd_op = 1'b0; bus_a.cmd_x = 8'd30; bus_a.cmd_y = 8'd20;
        bus_a.cmd_n = 4'd5; bus_a.cmd_addr = 12'h100; bus_a.cmd_valid = 1'b1;
        @(posedge SYS_CLK);
        #1 bus_a.cmd_valid = 1'b0;
        for (int cyc = 1; cyc <= 7; cyc++) begin
            @(negedge SYS_CLK);
            if (bus_a.mem_rd_en) rdn++;
            if (bus_a.done) saw_done = 1'b1;
        end
        chk("mid_rd_n", 64'(rdn), 64'd4);
        chk("mid_rd_en_before", 64'(bus_a.mem_rd_en), 64'd1);
        chk("mid_fb_nonzero", 64'(fb_a != '0), 64'd1);
        SYS_RST_N = 1'b0;
        #1;
        chk("mid_cmd_ready", 64'(bus_a.cmd_ready), 64'd1);
        chk("mid_rd_en", 64'(bus_a.mem_rd_en), 64'd0);
        chk("mid_mem_addr", 64'(bus_a.mem_addr), 64'd0);
        chk("mid_coll", 64'(bus_a.collision), 64'd0);
        exp_fb = '0;
        chk_fb("mid_fb", fb_a, exp_fb);
        for (int cyc = 0; cyc < 3; cyc++) begin
            @(negedge SYS_CLK);
            if (bus_a.done) saw_done = 1'b1;
        end
        SYS_RST_N = 1'b1;
        for (int cyc = 0; cyc < 3; cyc++) begin
            @(negedge SYS_CLK);
            if (bus_a.done) saw_done = 1'b1;
        end
        chk("mid_no_done", 64'(saw_done), 64'd0);
        chk("mid_ready_after", 64'(bus_a.cmd_ready), 64'd1);

        // LAT=3: cmd_valid held high; command changed to CLEAR while busy
        @(negedge SYS_CLK);
        bus_b.cmd_op = 1'b0; bus_b.cmd_x = 8'd10; bus_b.cmd_y = 8'd10;
        bus_b.cmd_n = 4'd3; bus_b.cmd_addr = 12'h300; bus_b.cmd_valid = 1'b1;
        @(posedge SYS_CLK);
        for (int cyc = 1; cyc <= 50; cyc++) begin
            @(negedge SYS_CLK);
            if (cyc == 3) bus_b.cmd_op = 1'b1;
            if (cyc == 15) bus_b.cmd_valid = 1'b0;
            if (bus_b.mem_rd_en) rdc.push_back(cyc);
            if (bus_b.done) dnc.push_back(cyc);
            if (bus_b.cmd_ready) ryc.push_back(cyc);
            if (cyc == 13) begin
                exp_fb = '0;
                px(10, 10); px(10, 11); px(10, 12);
                chk_fb("lat3_draw_fb", fb_b, exp_fb);
            end
        end
        chk("lat3_rd_n", 64'(rdc.size()), 64'd3);
        chk("lat3_rd_c0", 64'(rdc[0]), 64'd1);
        chk("lat3_rd_c1", 64'(rdc[1]), 64'd5);
        chk("lat3_rd_c2", 64'(rdc[2]), 64'd9);
        chk("lat3_done_n", 64'(dnc.size()), 64'd2);
        chk("lat3_done_c0", 64'(dnc[0]), 64'd13);
        chk("lat3_done_c1", 64'(dnc[1]), 64'd47);
        chk("lat3_ready_n", 64'(ryc.size()), 64'd4);
        chk("lat3_ready_c0", 64'(ryc[0]), 64'd14);
        chk("lat3_coll", 64'(bus_b.collision), 64'd0);
        exp_fb = '0;
        chk_fb("lat3_clear_fb", fb_b, exp_fb);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
